// File: rtl/uxa_ps2_pkg.sv
// -----------------------------------------------------------------------------
// uxa_ps2_pkg
// Shared types and constants for the PS/2 device-to-host frame receiver.
//   ps2_state_e    : receiver FSM states (IDLE / SHIFT / WRITE / BUMP)
//   PS2_FRAME_BITS : bits in one PS/2 frame (start, 8 data, parity, stop)
//   PS2_BYTE_W     : payload width handed to the byte FIFO
//   odd_parity_ok  : true when data plus parity bit hold an odd number of ones
// -----------------------------------------------------------------------------
package uxa_ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_BYTE_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2,
    BUMP  = 2'd3
  } ps2_state_e;

  function automatic logic odd_parity_ok(input logic [PS2_BYTE_W-1:0] data,
                                         input logic                  par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/uxa_ps2_receiver_if.sv
// -----------------------------------------------------------------------------
// uxa_ps2_receiver_if
// Receiver-to-FIFO bundle plus the receiver's error pulses.
//   d_o           : byte towards the FIFO data input
//   we_o          : FIFO write-enable pulse
//   wp_inc_o      : FIFO write-pointer increment pulse (cycle after we_o)
//   full_i        : FIFO full flag back to the receiver
//   parity_err_o  : dropped frame, parity failure
//   framing_err_o : dropped frame, bad start/stop bit or timeout
//   overrun_o     : good byte dropped because the FIFO was full
// master = receiver side, slave = FIFO / observer side.
// -----------------------------------------------------------------------------
interface uxa_ps2_receiver_if;
  import uxa_ps2_pkg::*;

  logic [PS2_BYTE_W-1:0] d_o;
  logic                  we_o;
  logic                  wp_inc_o;
  logic                  full_i;
  logic                  parity_err_o;
  logic                  framing_err_o;
  logic                  overrun_o;

  modport master (
    output d_o, we_o, wp_inc_o, parity_err_o, framing_err_o, overrun_o,
    input  full_i
  );

  modport slave (
    input  d_o, we_o, wp_inc_o, parity_err_o, framing_err_o, overrun_o,
    output full_i
  );

endinterface

// File: rtl/uxa_ps2_sync.sv
// -----------------------------------------------------------------------------
// uxa_ps2_sync
// Brings the asynchronous PS/2 clock and data pins into the system clock
// domain and detects falling edges of the PS/2 clock.
//   clk_i, rst_n_i : system clock, async active-low reset
//   ps2_c_i        : raw PS/2 clock pin
//   ps2_d_i        : raw PS/2 data pin
//   data_o         : synchronized data, valid to sample when fall_o is high
//   fall_o         : one-cycle strobe on a PS/2 clock falling edge
// All flops reset to 1 (the idle level of the bus) so releasing reset never
// produces a spurious falling edge.
// -----------------------------------------------------------------------------
module uxa_ps2_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic ps2_c_i,
  input  logic ps2_d_i,
  output logic data_o,
  output logic fall_o
);

  logic [1:0] c_sync_q;
  logic [1:0] d_sync_q;
  logic       c_prev_q;

  // Two-stage synchronizers plus one delayed copy of the clock for edge detect.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      c_prev_q <= 1'b1;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2_c_i};
      d_sync_q <= {d_sync_q[0], ps2_d_i};
      c_prev_q <= c_sync_q[1];
    end
  end

  // Data and clock take the same path length, so data is aligned with fall_o.
  assign data_o = d_sync_q[1];
  assign fall_o = c_prev_q & ~c_sync_q[1];

endmodule

// File: rtl/uxa_ps2_receiver.sv
// -----------------------------------------------------------------------------
// uxa_ps2_receiver
// Deserializes PS/2 device-to-host frames (start, 8 data LSB first, odd
// parity, stop) and pushes each good byte into the downstream byte FIFO with
// its two-step protocol: we_o first, wp_inc_o the following cycle.
//   sys_clk_i      : system clock
//   sys_reset_n_i  : async active-low reset
//   ps2_c_i/ps2_d_i: raw PS/2 clock and data pins
//   fifo           : FIFO bundle (d_o, we_o, wp_inc_o, full_i) + error pulses
//   TIMEOUT        : sys_clk cycles allowed between PS/2 falling edges in a frame
// -----------------------------------------------------------------------------
module uxa_ps2_receiver
  import uxa_ps2_pkg::*;
#(
  parameter int TIMEOUT = 2500
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_reset_n_i,
  input  logic                  ps2_c_i,
  input  logic                  ps2_d_i,
  uxa_ps2_receiver_if.master    fifo
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int SR_W  = PS2_FRAME_BITS - 1;

  logic data_s;
  logic fall_s;

  uxa_ps2_sync u_sync (
    .clk_i   (sys_clk_i),
    .rst_n_i (sys_reset_n_i),
    .ps2_c_i (ps2_c_i),
    .ps2_d_i (ps2_d_i),
    .data_o  (data_s),
    .fall_o  (fall_s)
  );

  ps2_state_e            state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [SR_W-1:0]       shift_q, shift_d;
  logic [PS2_BYTE_W-1:0] d_q, d_d;
  logic                  we_q, we_d;
  logic                  wp_inc_q, wp_inc_d;
  logic                  par_err_q, par_err_d;
  logic                  frm_err_q, frm_err_d;
  logic                  ovr_q, ovr_d;

  // Full frame as seen on the stop-bit edge: [0] start, [8:1] data, [9] parity, [10] stop.
  logic [PS2_FRAME_BITS-1:0] frame_s;
  assign frame_s = {data_s, shift_q};

  function automatic logic [TMO_W-1:0] tmo_inc(input logic [TMO_W-1:0] v);
    return (v == TMO_W'(TIMEOUT)) ? v : v + TMO_W'(1);
  endfunction

  // Next-state logic: bit collection, frame checks, timeout and FIFO handshake.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    shift_d   = shift_q;
    d_d       = d_q;
    par_err_d = 1'b0;
    frm_err_d = 1'b0;
    ovr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall_s) begin
          if (!data_s) begin
            // The start bit is kept at the bottom of the shift register.
            state_d   = SHIFT;
            bit_cnt_d = 4'd1;
            tmo_d     = '0;
            shift_d   = {data_s, {(SR_W-1){1'b0}}};
          end else begin
            frm_err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        if (fall_s) begin
          tmo_d = '0;
          if (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) begin
            // Stop bit: decide the fate of the frame in this very cycle.
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            shift_d   = '0;
            if (!frame_s[10] || frame_s[0]) begin
              frm_err_d = 1'b1;
            end else if (!odd_parity_ok(frame_s[8:1], frame_s[9])) begin
              par_err_d = 1'b1;
            end else if (fifo.full_i) begin
              ovr_d = 1'b1;
            end else begin
              state_d = WRITE;
              d_d     = frame_s[8:1];
            end
          end else begin
            shift_d   = frame_s[SR_W:1];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          // Counter reaches TIMEOUT this cycle: abandon the partial frame.
          frm_err_d = 1'b1;
          state_d   = IDLE;
          bit_cnt_d = 4'd0;
          tmo_d     = '0;
          shift_d   = '0;
        end else begin
          tmo_d = tmo_inc(tmo_q);
        end
      end

      WRITE: begin
        state_d = BUMP;
      end

      BUMP: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = 4'd0;
        tmo_d     = '0;
        shift_d   = '0;
      end
    endcase

    // Handshake pulses are registered images of the state being entered.
    we_d     = (state_d == WRITE);
    wp_inc_d = (state_d == BUMP);
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk_i or negedge sys_reset_n_i) begin
    if (!sys_reset_n_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      tmo_q     <= '0;
      shift_q   <= '0;
      d_q       <= 8'h00;
      we_q      <= 1'b0;
      wp_inc_q  <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      shift_q   <= shift_d;
      d_q       <= d_d;
      we_q      <= we_d;
      wp_inc_q  <= wp_inc_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign fifo.d_o           = d_q;
  assign fifo.we_o          = we_q;
  assign fifo.wp_inc_o      = wp_inc_q;
  assign fifo.parity_err_o  = par_err_q;
  assign fifo.framing_err_o = frm_err_q;
  assign fifo.overrun_o     = ovr_q;

endmodule

// File: tb/tb_uxa_ps2_receiver.sv
`timescale 1ns/1ps
// Scoreboard bench for uxa_ps2_receiver: stimulus pushes predicted events,
// a negedge monitor pops and compares whenever the DUT raises a pulse.
module tb_uxa_ps2_receiver;

  localparam int TIMEOUT  = 2500;
  localparam int EV_WRITE = 0;
  localparam int EV_PAR   = 1;
  localparam int EV_FRM   = 2;
  localparam int EV_OVR   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_c = 1'b1;
  logic ps2_d = 1'b1;

  uxa_ps2_receiver_if bus();

  uxa_ps2_receiver #(.TIMEOUT(TIMEOUT)) dut (
    .sys_clk_i     (clk),
    .sys_reset_n_i (rst_n),
    .ps2_c_i       (ps2_c),
    .ps2_d_i       (ps2_d),
    .fifo          (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         exp_kind_q[$];
  logic [7:0] exp_data_q[$];
  logic [7:0] last_d  = 8'h00;
  logic       prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: what a single frame should produce, from the protocol rules.
  function automatic int predict(input logic [7:0] b, input logic par,
                                 input logic stop, input logic full);
    int ones;
    ones = $countones(b) + int'(par);
    if (!stop)            return EV_FRM;
    if ((ones % 2) == 0)  return EV_PAR;
    if (full)             return EV_OVR;
    return EV_WRITE;
  endfunction

  function automatic logic odd_par(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  task automatic expect_ev(input int kind, input logic [7:0] data);
    exp_kind_q.push_back(kind);
    exp_data_q.push_back(data);
  endtask

  // One PS/2 bit: data set while clock high, then a low pulse; timing asynchronous to clk.
  task automatic send_bit(input logic v);
    int h;
    h = $urandom_range(90, 260);
    ps2_d = v;
    #(h / 2);
    ps2_c = 1'b0;
    #(h);
    ps2_c = 1'b1;
    #(h - h / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par,
                            input logic stop, input int nbits);
    logic [10:0] bits;
    bits = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(bits[i]);
    ps2_d = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input logic par,
                       input logic stop, input logic full);
    expect_ev(predict(b, par, stop, full), b);
    bus.full_i = full;
    send_frame(b, par, stop, 11);
    repeat (4) @(posedge clk);
    bus.full_i = 1'b0;
  endtask

  task automatic take_event(input int kind);
    int         ek;
    logic [7:0] ed;
    if (exp_kind_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d, required no event", kind);
    end else begin
      ek = exp_kind_q.pop_front();
      ed = exp_data_q.pop_front();
      check("event_kind", 32'(kind), 32'(ek));
      if (kind == EV_WRITE) begin
        check("write_data", 32'(bus.d_o), 32'(ed));
        last_d = ed;
      end else begin
        check("d_o_held", 32'(bus.d_o), 32'(last_d));
      end
    end
  endtask

  // Monitor: samples on the falling clock edge, away from DUT updates.
  always @(negedge clk) begin
    int nev;
    if (!rst_n) begin
      last_d  = 8'h00;
      prev_we = 1'b0;
    end else begin
      nev = int'(bus.we_o) + int'(bus.parity_err_o) + int'(bus.framing_err_o) + int'(bus.overrun_o);
      if (nev > 1) check("one_event_per_cycle", 32'(nev), 32'd1);
      if (bus.wp_inc_o || prev_we) check("wp_inc_after_we", 32'(bus.wp_inc_o), 32'(prev_we));
      prev_we = bus.we_o;
      if (bus.we_o)          take_event(EV_WRITE);
      if (bus.parity_err_o)  take_event(EV_PAR);
      if (bus.framing_err_o) take_event(EV_FRM);
      if (bus.overrun_o)     take_event(EV_OVR);
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_kind_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    check(name, 32'(exp_kind_q.size()), 32'd0);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bus.full_i = 1'b0;
    #1;
    check("reset_outputs",
          32'({bus.d_o, bus.we_o, bus.wp_inc_o, bus.parity_err_o, bus.framing_err_o, bus.overrun_o}),
          32'd0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Good frame, then same byte with wrong parity.
    frame(8'hB7, 1'b1, 1'b1, 1'b0);
    frame(8'hB7, 1'b0, 1'b1, 1'b0);
    // FIFO full -> overrun, then resend with room.
    frame(8'h1C, 1'b0, 1'b1, 1'b1);
    frame(8'h1C, 1'b0, 1'b1, 1'b0);
    drain("drain_directed");

    // Five bits then silence past the timeout; the next frame must be clean.
    expect_ev(EV_FRM, 8'h00);
    send_frame(8'h1C, 1'b0, 1'b1, 5);
    repeat (TIMEOUT + 40) @(posedge clk);
    check("timeout_event_seen", 32'(exp_kind_q.size()), 32'd0);
    frame(8'h1C, 1'b0, 1'b1, 1'b0);

    // A falling edge with data high while idle is a bad start bit.
    expect_ev(EV_FRM, 8'h00);
    send_bit(1'b1);
    drain("drain_bad_start");

    // Reset in the middle of a frame: nothing written, outputs cleared at once.
    send_frame(8'hA5, 1'b1, 1'b1, 4);
    #3 rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs",
          32'({bus.d_o, bus.we_o, bus.wp_inc_o, bus.parity_err_o, bus.framing_err_o, bus.overrun_o}),
          32'd0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    frame(8'hF0, 1'b1, 1'b1, 1'b0);
    drain("drain_after_reset");

    // Back-to-back frames, the third with a bad stop bit.
    frame(8'h12, 1'b1, 1'b1, 1'b0);
    frame(8'h34, 1'b0, 1'b1, 1'b0);
    frame(8'h56, odd_par(8'h56), 1'b0, 1'b0);
    drain("drain_back_to_back");

    // Randomized frames.
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      frame(b,
            ($urandom_range(0, 9) == 0) ? ~odd_par(b) : odd_par(b),
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 6) == 0);
    end
    drain("drain_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
